// File: rtl/time_of_day_counter_pkg.sv
// time_of_day_counter_pkg: shared mode encoding, field limits and binary-to-BCD helper
package time_of_day_counter_pkg;
  localparam logic MODE_12H = 1'b0;
  localparam logic MODE_24H = 1'b1;
  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;
  localparam int SEC_MAX = 59;
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    t = v >= 6'd50 ? 4'd5 : v >= 6'd40 ? 4'd4 : v >= 6'd30 ? 4'd3 :
        v >= 6'd20 ? 4'd2 : v >= 6'd10 ? 4'd1 : 4'd0;
    return {t, 4'(v - 6'(t) * 6'd10)};
  endfunction
endpackage

// File: rtl/time_of_day_counter_bcd.sv
// bcd_mod_counter: two-digit BCD counter wrapping at MOD_TENS:MOD_ONES with carry-out
module bcd_mod_counter #(
  parameter int MOD_TENS = 5,
  parameter int MOD_ONES = 9
) (
  input  logic       clk_100hz,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);
  logic term;
  assign term  = tens == 4'(MOD_TENS) && ones == 4'(MOD_ONES);
  assign carry = inc && term;
  always_ff @(posedge clk_100hz or negedge rst)
    if (!rst) begin
      tens <= '0;
      ones <= '0;
    end else if (load) begin
      tens <= load_tens;
      ones <= load_ones;
    end else if (inc) begin
      tens <= term ? 4'd0 : ones == 4'd9 ? tens + 4'd1 : tens;
      ones <= term || ones == 4'd9 ? 4'd0 : ones + 4'd1;
    end
endmodule

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: canonical 24h BCD clock with registered 12h/24h display digits
module time_of_day_counter
  import time_of_day_counter_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk_100hz,
  input  logic       rst,
  input  logic       mode,
  input  logic       run,
  input  logic       load,
  input  logic [4:0] load_hr,
  input  logic [5:0] load_min,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       pm,
  output logic       sec_tick
);
  localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  logic [PW-1:0] presc;
  logic load_ok, tick, sec_carry, min_carry, hr_term;
  logic [3:0] st, so, mt, mo, ht, ho;
  logic [4:0] h24, h12;
  logic [7:0] lmin, lhr, d12;
  assign load_ok = load && load_hr <= 5'(HR_MAX) && load_min <= 6'(MIN_MAX);
  assign tick    = run && !load_ok && presc == PW'(TICKS_PER_SEC - 1);
  assign lmin    = to_bcd(load_min);
  assign lhr     = to_bcd({1'b0, load_hr});
  assign h24     = 5'(ht) * 5'd10 + 5'(ho);
  assign hr_term = h24 == 5'(HR_MAX);
  assign h12     = h24 == 5'd0 ? 5'd12 : h24 > 5'd12 ? h24 - 5'd12 : h24;
  assign d12     = to_bcd({1'b0, h12});
  always_ff @(posedge clk_100hz or negedge rst)
    if (!rst) presc <= '0;
    else if (load_ok || tick) presc <= '0;
    else if (run) presc <= presc + PW'(1);
  bcd_mod_counter #(.MOD_TENS(SEC_MAX / 10), .MOD_ONES(SEC_MAX % 10)) u_sec (
    .clk_100hz(clk_100hz), .rst(rst), .inc(tick), .load(load_ok),
    .load_tens(4'd0), .load_ones(4'd0), .tens(st), .ones(so), .carry(sec_carry)
  );
  bcd_mod_counter #(.MOD_TENS(MIN_MAX / 10), .MOD_ONES(MIN_MAX % 10)) u_min (
    .clk_100hz(clk_100hz), .rst(rst), .inc(sec_carry), .load(load_ok),
    .load_tens(lmin[7:4]), .load_ones(lmin[3:0]), .tens(mt), .ones(mo), .carry(min_carry)
  );
  always_ff @(posedge clk_100hz or negedge rst)
    if (!rst) begin
      ht <= '0;
      ho <= '0;
    end else if (load_ok) begin
      ht <= lhr[7:4];
      ho <= lhr[3:0];
    end else if (min_carry) begin
      ht <= hr_term ? 4'd0 : ho == 4'd9 ? ht + 4'd1 : ht;
      ho <= hr_term || ho == 4'd9 ? 4'd0 : ho + 4'd1;
    end
  // Display registers sample the canonical count, so digits trail the count by one cycle.
  always_ff @(posedge clk_100hz or negedge rst)
    if (!rst) begin
      {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones} <= '0;
      pm       <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      hr_tens  <= mode == MODE_24H ? ht : d12[7:4];
      hr_ones  <= mode == MODE_24H ? ho : d12[3:0];
      min_tens <= mt;
      min_ones <= mo;
      sec_tens <= st;
      sec_ones <= so;
      pm       <= h24 >= 5'd12;
      sec_tick <= tick;
    end
endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: directed self-checking bench for time_of_day_counter
module tb_time_of_day_counter;
  logic clk_100hz = 1'b0;
  logic rst = 1'b0, mode = 1'b0, run = 1'b0, load = 1'b0;
  logic [4:0] load_hr = '0;
  logic [5:0] load_min = '0;
  logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic pm, sec_tick;
  logic [23:0] disp;
  int vectors = 0, miscompares = 0;

  time_of_day_counter #(.TICKS_PER_SEC(4)) dut (
    .clk_100hz(clk_100hz), .rst(rst), .mode(mode), .run(run), .load(load),
    .load_hr(load_hr), .load_min(load_min), .hr_tens(hr_tens), .hr_ones(hr_ones),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .pm(pm), .sec_tick(sec_tick)
  );

  assign disp = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
  always #5 clk_100hz = ~clk_100hz;

  task automatic step(input int n);
    repeat (n) @(negedge clk_100hz);
  endtask

  task automatic do_load(input logic [4:0] h, input logic [5:0] m);
    load = 1'b1; load_hr = h; load_min = m;
    step(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if ({disp, pm, sec_tick} !== {24'h000000, 2'b00}) begin
      miscompares++; $display("FAIL reset_hold got %h pm=%b tick=%b exp 000000 0 0", disp, pm, sec_tick);
    end
    step(1); rst = 1'b1; step(1);
    vectors++;
    if ({disp, pm} !== {24'h120000, 1'b0}) begin
      miscompares++; $display("FAIL reset_12h got %h pm=%b exp 120000 0", disp, pm);
    end
    mode = 1'b1; step(1);
    vectors++;
    if (disp !== 24'h000000) begin
      miscompares++; $display("FAIL reset_24h got %h exp 000000", disp);
    end
  endtask

  task automatic test_count;
    int ticks = 0;
    run = 1'b1;
    for (int i = 0; i < 240; i++) begin
      step(1);
      if (sec_tick) ticks++;
      if (i == 3) begin
        vectors++;
        if (sec_tick !== 1'b1 || sec_ones !== 4'd0) begin
          miscompares++; $display("FAIL first_tick got tick=%b ones=%0d exp 1 0", sec_tick, sec_ones);
        end
      end
      if (i == 4) begin
        vectors++;
        if (sec_tick !== 1'b0 || sec_ones !== 4'd1) begin
          miscompares++; $display("FAIL first_sec got tick=%b ones=%0d exp 0 1", sec_tick, sec_ones);
        end
      end
    end
    run = 1'b0; step(1);
    vectors++;
    if (disp !== 24'h000100 || ticks != 60) begin
      miscompares++; $display("FAIL one_minute got %h ticks=%0d exp 000100 60", disp, ticks);
    end
  endtask

  task automatic test_day_wrap;
    do_load(5'd23, 6'd59);
    run = 1'b1; step(236);
    run = 1'b0; step(1);
    vectors++;
    if ({disp, pm} !== {24'h235959, 1'b1}) begin
      miscompares++; $display("FAIL pre_wrap_24h got %h pm=%b exp 235959 1", disp, pm);
    end
    mode = 1'b0; step(1);
    vectors++;
    if ({disp, pm} !== {24'h115959, 1'b1}) begin
      miscompares++; $display("FAIL pre_wrap_12h got %h pm=%b exp 115959 1", disp, pm);
    end
    run = 1'b1; step(4);
    run = 1'b0; step(1);
    vectors++;
    if ({disp, pm} !== {24'h120000, 1'b0}) begin
      miscompares++; $display("FAIL wrap_12h got %h pm=%b exp 120000 0", disp, pm);
    end
    mode = 1'b1; step(1);
    vectors++;
    if ({disp, pm} !== {24'h000000, 1'b0}) begin
      miscompares++; $display("FAIL wrap_24h got %h pm=%b exp 000000 0", disp, pm);
    end
  endtask

  task automatic test_12h_map;
    logic [4:0]  hrs [5] = '{5'd12, 5'd13, 5'd0, 5'd11, 5'd23};
    logic [5:0]  mins[5] = '{6'd0, 6'd34, 6'd5, 6'd59, 6'd7};
    logic [24:0] exp [5] = '{{24'h120000, 1'b1}, {24'h013400, 1'b1}, {24'h120500, 1'b0},
                             {24'h115900, 1'b0}, {24'h110700, 1'b1}};
    mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_load(hrs[i], mins[i]); step(1);
      vectors++;
      if ({disp, pm} !== exp[i]) begin
        miscompares++; $display("FAIL map12_%0d got %h pm=%b exp %h", hrs[i], disp, pm, exp[i]);
      end
    end
  endtask

  task automatic test_load;
    mode = 1'b1;
    do_load(5'd10, 6'd20);
    do_load(5'd24, 6'd5); step(1);
    vectors++;
    if (disp !== 24'h102000) begin
      miscompares++; $display("FAIL bad_hour got %h exp 102000", disp);
    end
    do_load(5'd5, 6'd60); step(1);
    vectors++;
    if (disp !== 24'h102000) begin
      miscompares++; $display("FAIL bad_min got %h exp 102000", disp);
    end
    run = 1'b1; step(3);
    do_load(5'd7, 6'd8);
    vectors++;
    if (sec_tick !== 1'b0) begin
      miscompares++; $display("FAIL load_vs_tick got tick=%b exp 0", sec_tick);
    end
    step(1);
    vectors++;
    if (disp !== 24'h070800 || sec_tick !== 1'b0) begin
      miscompares++; $display("FAIL load_priority got %h tick=%b exp 070800 0", disp, sec_tick);
    end
    step(3);
    vectors++;
    if (sec_tick !== 1'b1) begin
      miscompares++; $display("FAIL post_load_tick got %b exp 1", sec_tick);
    end
    run = 1'b0; step(1);
  endtask

  task automatic test_freeze_mode_reset;
    int ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (sec_tick) ticks++;
    end
    vectors++;
    if (disp !== 24'h070801 || ticks != 0) begin
      miscompares++; $display("FAIL frozen got %h ticks=%0d exp 070801 0", disp, ticks);
    end
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mode = ~mode;
      step(1);
      vectors++;
      if (sec_tick !== (i == 3 || i == 7)) begin
        miscompares++; $display("FAIL toggle_tick_%0d got %b exp %b", i, sec_tick, i == 3 || i == 7);
      end
    end
    run = 1'b0; mode = 1'b1; step(1);
    vectors++;
    if (disp !== 24'h070803) begin
      miscompares++; $display("FAIL after_toggle got %h exp 070803", disp);
    end
    run = 1'b1; step(2);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({disp, pm, sec_tick} !== {24'h000000, 2'b00}) begin
      miscompares++; $display("FAIL async_reset got %h pm=%b tick=%b exp 000000 0 0", disp, pm, sec_tick);
    end
    run = 1'b0; step(1); rst = 1'b1; step(2);
    vectors++;
    if (disp !== 24'h000000) begin
      miscompares++; $display("FAIL post_reset got %h exp 000000", disp);
    end
  endtask

  initial begin
    test_reset;
    test_count;
    test_day_wrap;
    test_12h_map;
    test_load;
    test_freeze_mode_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
